roulette_lcd_driver: RTL and testbench

Consumer end of the roulette wheel's display interface: takes the BCD digit pair and display-mode code produced by the roulette wheel and writes them to an HD44780-compatible character LCD over an 8-bit parallel, write-only bus. On reset it runs the LCD power-up and initialisation sequence. It then rewrites a fixed 4-character field whenever its inputs change. It sits between the roulette wheel and the board's LCD header.

---
 rtl/roulette_pkg.sv | 51 +++++
 rtl/roulette_lcd_driver_byte_writer.sv | 100 ++++++++++
 rtl/roulette_lcd_driver.sv | 173 +++++++++++++++++
 tb/tb_roulette_lcd_driver.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/roulette_pkg.sv
// Encodings and constants shared between the roulette wheel and its LCD driver,
// plus the BCD-to-character mapping used when the display field is rewritten.
package roulette_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE        = 2'b00,
        MODE_SPINNING    = 2'b01,
        MODE_SHOW_RESULT = 2'b10
    } display_mode_e;

    localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;
    localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR        = 8'h01;
    localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
    localparam logic [7:0] CMD_SET_DDRAM    = 8'h80;

    localparam logic [7:0] CHAR_DIGIT0 = 8'h30;
    localparam logic [7:0] CHAR_BLANK  = 8'h20;
    localparam logic [7:0] CHAR_QUERY  = 8'h3F;
    localparam logic [7:0] CHAR_I      = 8'h49;
    localparam logic [7:0] CHAR_S      = 8'h53;
    localparam logic [7:0] CHAR_R      = 8'h52;

    typedef enum logic [2:0] {
        BW_IDLE,
        BW_SETUP,
        BW_PULSE,
        BW_HOLD,
        BW_WAIT
    } bw_state_e;

    typedef enum logic [1:0] {
        S_POWER_WAIT,
        S_INIT,
        S_IDLE,
        S_UPDATE
    } top_state_e;

    // blank_zero gives leading-zero suppression for the tens position.
    function automatic logic [7:0] digit_char(input logic [3:0] d, input logic blank_zero);
        if (d == 4'hF)
            return CHAR_BLANK;
        else if (d > 4'd9)
            return CHAR_QUERY;
        else if (blank_zero && d == 4'd0)
            return CHAR_BLANK;
        else
            return CHAR_DIGIT0 + {4'h0, d};
    endfunction

endpackage

// File: rtl/roulette_lcd_driver_byte_writer.sv
// Drives one LCD bus write: SETUP, E pulse, HOLD, then the post-write wait.
// RS/data are registered at start and held until the next byte's SETUP.
module lcd_byte_writer
    import roulette_pkg::*;
#(
    parameter logic [31:0] E_CYC   = 32'd1,
    parameter logic [31:0] CMD_CYC = 32'd160,
    parameter logic [31:0] CLR_CYC = 32'd6560
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       done,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    bw_state_e   state, state_n;
    logic [31:0] cnt, cnt_n;
    logic        rs_q, rs_n;
    logic [7:0]  data_q, data_n;
    logic        long_q, long_n;
    logic        e_q;
    logic [31:0] wait_len;

    assign wait_len = long_q ? CLR_CYC : CMD_CYC;

    // A start in the final WAIT cycle is accepted so bytes run back-to-back.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rs_n    = rs_q;
        data_n  = data_q;
        long_n  = long_q;
        done    = 1'b0;
        case (state)
            BW_IDLE: ;
            BW_SETUP: begin
                state_n = BW_PULSE;
                cnt_n   = 32'd0;
            end
            BW_PULSE: begin
                if (cnt == E_CYC - 32'd1) begin
                    state_n = BW_HOLD;
                    cnt_n   = 32'd0;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            BW_HOLD: begin
                state_n = BW_WAIT;
                cnt_n   = 32'd0;
            end
            BW_WAIT: begin
                if (cnt == wait_len - 32'd1) begin
                    done    = 1'b1;
                    state_n = BW_IDLE;
                    cnt_n   = 32'd0;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            default: state_n = BW_IDLE;
        endcase
        if (start && (state == BW_IDLE || done)) begin
            state_n = BW_SETUP;
            cnt_n   = 32'd0;
            rs_n    = rs;
            data_n  = data;
            long_n  = long_wait;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= BW_IDLE;
            cnt    <= 32'd0;
            rs_q   <= 1'b0;
            data_q <= 8'h00;
            long_q <= 1'b0;
            e_q    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rs_q   <= rs_n;
            data_q <= data_n;
            long_q <= long_n;
            e_q    <= (state_n == BW_PULSE);
        end
    end

    assign lcd_rs   = rs_q;
    assign lcd_data = data_q;
    assign lcd_e    = e_q;

endmodule

// File: rtl/roulette_lcd_driver.sv
// HD44780 driver for the roulette display: power-up wait, init sequence, then
// rewrites a 4-character field (tens, ones, blank, status) whenever inputs change.
module roulette_lcd_driver
    import roulette_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int POWERUP_MS = 40,
    parameter int CMD_US     = 40,
    parameter int CLEAR_US   = 1640
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_ones,
    input  logic [1:0] display_mode,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       ready
);

    localparam int E_DIV = CLOCK_FREQ / 4_000_000;
    localparam logic [31:0] E_CYC   = (E_DIV < 1) ? 32'd1 : E_DIV;
    localparam logic [31:0] PWR_CYC = CLOCK_FREQ / 1000 * POWERUP_MS;
    localparam logic [31:0] CMD_CYC = CLOCK_FREQ / 1_000_000 * CMD_US;
    localparam logic [31:0] CLR_CYC = CLOCK_FREQ / 1_000_000 * CLEAR_US;

    top_state_e  state, state_n;
    logic [31:0] pwr_cnt, pwr_cnt_n;
    logic [2:0]  idx, idx_n, sel_idx, last_idx;
    logic        launched, launched_n;
    logic [3:0]  snap_tens, snap_tens_n, snap_ones, snap_ones_n;
    logic [1:0]  snap_mode, snap_mode_n;
    logic        force_upd, force_upd_n;
    logic        ready_q;

    logic        bw_start, bw_rs, bw_long, bw_done;
    logic [7:0]  bw_data, status_char;

    lcd_byte_writer #(
        .E_CYC  (E_CYC),
        .CMD_CYC(CMD_CYC),
        .CLR_CYC(CLR_CYC)
    ) u_writer (
        .clk      (clk),
        .reset    (reset),
        .start    (bw_start),
        .rs       (bw_rs),
        .data     (bw_data),
        .long_wait(bw_long),
        .done     (bw_done),
        .lcd_rs   (lcd_rs),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data)
    );

    always_comb begin
        status_char = CHAR_QUERY;
        case (snap_mode)
            MODE_IDLE:        status_char = CHAR_I;
            MODE_SPINNING:    status_char = CHAR_S;
            MODE_SHOW_RESULT: status_char = CHAR_R;
            default:          status_char = CHAR_QUERY;
        endcase
    end

    // On done the next byte is presented in the same cycle, so look one index ahead.
    assign sel_idx  = bw_done ? idx + 3'd1 : idx;
    assign last_idx = (state == S_INIT) ? 3'd3 : 3'd4;

    always_comb begin
        bw_rs   = 1'b0;
        bw_data = CMD_SET_DDRAM;
        bw_long = 1'b0;
        if (state == S_INIT) begin
            case (sel_idx)
                3'd0:    bw_data = CMD_FUNCTION_SET;
                3'd1:    bw_data = CMD_DISPLAY_ON;
                3'd2:    bw_data = CMD_CLEAR;
                default: bw_data = CMD_ENTRY_MODE;
            endcase
            bw_long = (bw_data == CMD_CLEAR);
        end else begin
            bw_rs = (sel_idx != 3'd0);
            case (sel_idx)
                3'd0:    bw_data = CMD_SET_DDRAM;
                3'd1:    bw_data = digit_char(snap_tens, 1'b1);
                3'd2:    bw_data = digit_char(snap_ones, 1'b0);
                3'd3:    bw_data = CHAR_BLANK;
                default: bw_data = status_char;
            endcase
        end
    end

    always_comb begin
        state_n     = state;
        pwr_cnt_n   = pwr_cnt;
        idx_n       = idx;
        launched_n  = launched;
        snap_tens_n = snap_tens;
        snap_ones_n = snap_ones;
        snap_mode_n = snap_mode;
        force_upd_n = force_upd;
        bw_start    = 1'b0;
        case (state)
            S_POWER_WAIT: begin
                // Exit one cycle early: the writer's SETUP cycle completes the wait.
                if (pwr_cnt >= PWR_CYC - 32'd2) begin
                    state_n    = S_INIT;
                    idx_n      = 3'd0;
                    launched_n = 1'b0;
                end else begin
                    pwr_cnt_n = pwr_cnt + 32'd1;
                end
            end
            S_INIT, S_UPDATE: begin
                if (!launched) begin
                    bw_start   = 1'b1;
                    launched_n = 1'b1;
                end else if (bw_done) begin
                    if (idx == last_idx) begin
                        state_n = S_IDLE;
                    end else begin
                        bw_start = 1'b1;
                        idx_n    = idx + 3'd1;
                    end
                end
            end
            S_IDLE: begin
                if (force_upd || bcd_tens != snap_tens || bcd_ones != snap_ones ||
                    display_mode != snap_mode) begin
                    snap_tens_n = bcd_tens;
                    snap_ones_n = bcd_ones;
                    snap_mode_n = display_mode;
                    force_upd_n = 1'b0;
                    idx_n       = 3'd0;
                    launched_n  = 1'b0;
                    state_n     = S_UPDATE;
                end
            end
            default: state_n = S_POWER_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_POWER_WAIT;
            pwr_cnt   <= 32'd0;
            idx       <= 3'd0;
            launched  <= 1'b0;
            snap_tens <= 4'hF;
            snap_ones <= 4'hF;
            snap_mode <= 2'b00;
            force_upd <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state     <= state_n;
            pwr_cnt   <= pwr_cnt_n;
            idx       <= idx_n;
            launched  <= launched_n;
            snap_tens <= snap_tens_n;
            snap_ones <= snap_ones_n;
            snap_mode <= snap_mode_n;
            force_upd <= force_upd_n;
            ready_q   <= (state == S_IDLE);
        end
    end

    assign ready  = ready_q;
    assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_roulette_lcd_driver.sv
// Bench for roulette_lcd_driver: a negedge bus monitor pops expected {rs,data}
// bytes from a queue and checks power-up delay, byte spacing and data stability.
module tb_roulette_lcd_driver;

    localparam int PWR_CYC = 4000;
    localparam int E_CYC   = 1;
    localparam int CMD_CYC = 160;
    localparam int CLR_CYC = 6560;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] bcd_tens, bcd_ones;
    logic [1:0] display_mode;
    logic       lcd_rs, lcd_rw, lcd_e, ready;
    logic [7:0] lcd_data;

    int checks = 0;
    int errors = 0;
    int rel_cyc = 0;
    int bytes_seen = 0;
    logic [8:0] exp_q[$];

    typedef struct {
        logic [3:0] tens;
        logic [3:0] ones;
        logic [1:0] mode;
        logic [7:0] tens_ch;
        logic [7:0] ones_ch;
        logic [7:0] stat_ch;
    } vec_t;

    vec_t vecs[6];

    roulette_lcd_driver #(
        .CLOCK_FREQ(4_000_000),
        .POWERUP_MS(1),
        .CMD_US    (40),
        .CLEAR_US  (1640)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bcd_tens    (bcd_tens),
        .bcd_ones    (bcd_ones),
        .display_mode(display_mode),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_e       (lcd_e),
        .lcd_data    (lcd_data),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // cycles since reset release
    initial begin
        forever begin
            @(posedge clk);
            if (reset) rel_cyc = 0;
            else       rel_cyc = rel_cyc + 1;
        end
    end

    initial begin
        logic       prev_e;
        logic       have_prev;
        int         prev_rise;
        logic [8:0] prev_byte, cur, cap, exp;
        prev_e = 1'b0;
        have_prev = 1'b0;
        prev_rise = 0;
        prev_byte = 9'h0;
        cap = 9'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_e = 1'b0;
                have_prev = 1'b0;
            end else begin
                if (lcd_e && !prev_e) begin
                    cur = {lcd_rs, lcd_data};
                    cap = cur;
                    bytes_seen++;
                    if (!have_prev)
                        check("first_e_rise_cycle", rel_cyc, PWR_CYC + 1);
                    else if (!(cur == 9'h080 || cur == 9'h038))
                        check("byte_spacing", rel_cyc - prev_rise,
                              2 + E_CYC + ((prev_byte == 9'h001) ? CLR_CYC : CMD_CYC));
                    have_prev = 1'b1;
                    prev_rise = rel_cyc;
                    prev_byte = cur;
                    check("lcd_rw", {31'd0, lcd_rw}, 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got 0x%0h, required none", cur);
                    end else begin
                        exp = exp_q.pop_front();
                        check("lcd_byte", {23'd0, cur}, {23'd0, exp});
                    end
                end else if (lcd_e || prev_e) begin
                    check("data_stable", {23'd0, lcd_rs, lcd_data}, {23'd0, cap});
                end
                prev_e = lcd_e;
            end
        end
    end

    task automatic push_update(input logic [7:0] t, input logic [7:0] o, input logic [7:0] s);
        exp_q.push_back(9'h080);
        exp_q.push_back({1'b1, t});
        exp_q.push_back({1'b1, o});
        exp_q.push_back(9'h120);
        exp_q.push_back({1'b1, s});
    endtask

    task automatic push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
        push_update(8'h20, 8'h20, 8'h49);
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (ready === 1'b1 && exp_q.size() == 0) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_idle: ready=%0b pending=%0d, required ready=1 pending=0",
                     ready, exp_q.size());
        end
    endtask

    task automatic drive(input logic [3:0] t, input logic [3:0] o, input logic [1:0] m);
        bcd_tens = t;
        bcd_ones = o;
        display_mode = m;
    endtask

    initial begin
        bit ok;
        int base;
        vecs[0] = '{4'd3, 4'd6, 2'b10, 8'h33, 8'h36, 8'h52};
        vecs[1] = '{4'd0, 4'd7, 2'b10, 8'h20, 8'h37, 8'h52};
        vecs[2] = '{4'hA, 4'hF, 2'b11, 8'h3F, 8'h20, 8'h3F};
        vecs[3] = '{4'd9, 4'd0, 2'b01, 8'h39, 8'h30, 8'h53};
        vecs[4] = '{4'hF, 4'd5, 2'b00, 8'h20, 8'h35, 8'h49};
        vecs[5] = '{4'hE, 4'hB, 2'b01, 8'h3F, 8'h3F, 8'h53};

        reset = 1'b1;
        drive(4'hF, 4'hF, 2'b00);
        #22;
        check("reset_lcd_e", {31'd0, lcd_e}, 32'd0);
        check("reset_lcd_rs", {31'd0, lcd_rs}, 32'd0);
        check("reset_lcd_rw", {31'd0, lcd_rw}, 32'd0);
        check("reset_lcd_data", {24'd0, lcd_data}, 32'd0);
        check("reset_ready", {31'd0, ready}, 32'd0);

        push_init();
        @(negedge clk);
        reset = 1'b0;
        wait_idle(30000);

        foreach (vecs[k]) begin
            push_update(vecs[k].tens_ch, vecs[k].ones_ch, vecs[k].stat_ch);
            drive(vecs[k].tens, vecs[k].ones, vecs[k].mode);
            @(posedge clk); #1;
            check("ready_at_sample_edge", {31'd0, ready}, 32'd1);
            @(posedge clk); #1;
            check("ready_fall", {31'd0, ready}, 32'd0);
            check("addr_setup_data", {24'd0, lcd_data}, 32'h80);
            check("addr_setup_rs", {31'd0, lcd_rs}, 32'd0);
            check("addr_setup_e", {31'd0, lcd_e}, 32'd0);
            @(posedge clk); #1;
            check("addr_e_rise", {31'd0, lcd_e}, 32'd1);
            wait_idle(5000);
        end

        // input change while the tens byte is on the bus
        push_update(8'h33, 8'h36, 8'h52);
        base = bytes_seen;
        drive(4'd3, 4'd6, 2'b10);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (bytes_seen >= base + 2) ok = 1'b1;
        end
        check("mid_update_reached", {31'd0, ok}, 32'd1);
        push_update(8'h31, 8'h32, 8'h53);
        drive(4'd1, 4'd2, 2'b01);
        wait_idle(5000);

        // reset while E is high
        exp_q.push_back(9'h080);
        drive(4'd5, 4'd5, 2'b00);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (lcd_e === 1'b1) ok = 1'b1;
        end
        check("e_high_before_reset", {31'd0, ok}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_lcd_e", {31'd0, lcd_e}, 32'd0);
        check("async_reset_ready", {31'd0, ready}, 32'd0);
        check("async_reset_lcd_data", {24'd0, lcd_data}, 32'd0);
        check("async_reset_lcd_rs", {31'd0, lcd_rs}, 32'd0);
        exp_q.delete();
        drive(4'hF, 4'hF, 2'b00);
        repeat (3) @(negedge clk);
        push_init();
        reset = 1'b0;
        wait_idle(30000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
